uart_rx_core: RTL
=================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port baud_div  input  20  clk cycles per bit; values below 4 are treated as 4.
REQ-006 SHALL have port parity_en  input  1  parity bit present after the data bits.
REQ-007 SHALL have port parity_odd  input  1  odd parity when 1, even parity when 0.
REQ-008 SHALL have port data_o  output  DATA_BITS  received word, LSB = first data bit.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o&ready_i.
REQ-011 SHALL have port rts_o  output  1  high = far end may send; equals !valid_o.
REQ-012 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-013 SHALL have ports frame_err_o, parity_err_o, overrun_err_o  output  1 each  single-cycle error pulses.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: a synchronized high-to-low transition -> START; baud_div, parity_en and parity_odd are latched at this point and held for the frame.
REQ-017 START: after floor(div/2) cycles, sample rx: low -> DATA with the bit timer reset; high -> IDLE (glitch rejected, no flags).
REQ-018 DATA: sample one bit every div cycles at mid-bit, shift in LSB first; after DATA_BITS samples go to PARITY if parity enabled, otherwise STOP.
REQ-019 PARITY: sample one bit div cycles later; error if XOR(data, parity bit) != parity_odd.
REQ-020 STOP: sample div cycles later; high = valid stop, low = framing error.
REQ-021 On the stop-bit sample, frame_err_o SHALL pulse on a low stop bit, and parity_err_o SHALL pulse on a parity error with a high stop bit; any error discards the word.
REQ-022 A good frame SHALL load data_o and set valid_o on the cycle after the stop-bit sample, provided the holding register is empty or valid_o&ready_i holds in that same cycle.
REQ-023 A good frame arriving with valid_o=1 and ready_i=0 SHALL be dropped with an overrun_err_o pulse; data_o remains unchanged.
REQ-024 valid_o SHALL stay high, with data_o stable, until the cycle after valid_o&ready_i.
REQ-025 After the stop-bit sample the FSM SHALL return to IDLE, so a start edge in the second half of the stop bit is accepted.
REQ-026 After a framing error the FSM SHALL wait in IDLE until rx is high before arming start detection (break tolerance).
REQ-027 Bit timer SHALL be a 20-bit down-counter; a 4-bit bit counter SHALL support DATA_BITS 5..9.
REQ-028 Changes to baud_div or parity inputs mid-frame SHALL have no effect until the next start edge.

Reset
REQ-029 On reset: state IDLE; synchronizer 1; data_o 0; valid_o 0; rts_o 1; busy_o 0; all error pulses 0; counters 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without flags, and no partial word SHALL appear.

Verification
REQ-031 baud_div=16, no parity, frame 0xA5, ready_i=1 -> valid_o high one cycle with data_o=0xA5 about 9.5 bit times after the start edge; no error flags.
REQ-032 parity_en=1, parity_odd=0, frame 0x07 sent with parity bit 0 -> parity_err_o pulses once, valid_o stays 0.
REQ-033 rx low for 4 cycles at baud_div=16 -> returns to IDLE, busy_o falls, no flags, no valid_o.
REQ-034 Frame 0x3C with stop bit low, then rx held low 40 cycles -> frame_err_o pulses once; no new frame starts until rx returns high.
REQ-035 ready_i=0, frames 0x11 then 0x22 -> data_o=0x11 held, overrun_err_o pulses on the second frame; raising ready_i clears valid_o and sets rts_o=1.
REQ-036 reset asserted during the DATA state of frame 0x55, then frame 0x99 sent -> only 0x99 delivered.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop rx synchronizer, mid-bit sampling FSM, optional parity,
// and a one-word holding register with a valid/ready handshake.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [19:0]          baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 rts_o,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic                 armed_reg, armed_next;
    logic [19:0]          div_reg, div_next;
    logic [19:0]          timer_reg, timer_next;
    logic                 par_en_reg, par_en_next;
    logic                 par_odd_reg, par_odd_next;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_acc_reg, par_acc_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 parity_err_reg, parity_err_next;
    logic                 overrun_err_reg, overrun_err_next;

    logic [19:0] div_eff;
    logic        tick;
    logic        start_edge;
    logic        last_bit;
    logic        take;

    assign div_eff    = (baud_div < 20'd4) ? 20'd4 : baud_div;
    assign tick       = (timer_reg == 20'd0);
    // armed_reg stays low after a framing error until the line has returned high
    assign start_edge = armed_reg & rx_prev_reg & ~rx_sync_reg;
    assign last_bit   = (bit_cnt_reg == 4'(DATA_BITS - 1));
    assign take       = valid_reg & ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg     <= 1'b1;
            rx_sync_reg     <= 1'b1;
            rx_prev_reg     <= 1'b1;
            state_reg       <= IDLE;
            armed_reg       <= 1'b1;
            div_reg         <= 20'd0;
            timer_reg       <= 20'd0;
            par_en_reg      <= 1'b0;
            par_odd_reg     <= 1'b0;
            bit_cnt_reg     <= 4'd0;
            shift_reg       <= '0;
            par_acc_reg     <= 1'b0;
            data_reg        <= '0;
            valid_reg       <= 1'b0;
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            rx_meta_reg     <= rx;
            rx_sync_reg     <= rx_meta_reg;
            rx_prev_reg     <= rx_sync_reg;
            state_reg       <= state_next;
            armed_reg       <= armed_next;
            div_reg         <= div_next;
            timer_reg       <= timer_next;
            par_en_reg      <= par_en_next;
            par_odd_reg     <= par_odd_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            par_acc_reg     <= par_acc_next;
            data_reg        <= data_next;
            valid_reg       <= valid_next;
            frame_err_reg   <= frame_err_next;
            parity_err_reg  <= parity_err_next;
            overrun_err_reg <= overrun_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        armed_next       = armed_reg;
        div_next         = div_reg;
        timer_next       = timer_reg;
        par_en_next      = par_en_reg;
        par_odd_next     = par_odd_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        par_acc_next     = par_acc_reg;
        data_next        = data_reg;
        valid_next       = valid_reg & ~take;
        frame_err_next   = 1'b0;
        parity_err_next  = 1'b0;
        overrun_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_sync_reg) begin
                    armed_next = 1'b1;
                end
                if (start_edge) begin
                    state_next   = START;
                    div_next     = div_eff;
                    par_en_next  = parity_en;
                    par_odd_next = parity_odd;
                    timer_next   = (div_eff >> 1) - 20'd1;
                    bit_cnt_next = 4'd0;
                    par_acc_next = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_sync_reg) begin
                        state_next = DATA;
                        timer_next = div_reg - 20'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg - 20'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next   = {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                    par_acc_next = par_acc_reg ^ rx_sync_reg;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    timer_next   = div_reg - 20'd1;
                    if (last_bit) begin
                        state_next = par_en_reg ? PARITY : STOP;
                    end
                end else begin
                    timer_next = timer_reg - 20'd1;
                end
            end
            PARITY: begin
                if (tick) begin
                    par_acc_next = par_acc_reg ^ rx_sync_reg;
                    timer_next   = div_reg - 20'd1;
                    state_next   = STOP;
                end else begin
                    timer_next = timer_reg - 20'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    if (!rx_sync_reg) begin
                        frame_err_next = 1'b1;
                        armed_next     = 1'b0;
                    end else if (par_en_reg && (par_acc_reg != par_odd_reg)) begin
                        parity_err_next = 1'b1;
                    end else if (valid_reg && !ready_i) begin
                        overrun_err_next = 1'b1;
                    end else begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - 20'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data_o        = data_reg;
    assign valid_o       = valid_reg;
    assign rts_o         = ~valid_reg;
    assign busy_o        = (state_reg != IDLE);
    assign frame_err_o   = frame_err_reg;
    assign parity_err_o  = parity_err_reg;
    assign overrun_err_o = overrun_err_reg;

endmodule
